// File: rtl/pixel_write_packer.sv
// Packs an 8-bit pixel stream into masked 32-bit SRAM write words with
// sequential word addresses, one-word output register and ready/valid on both sides.
module pixel_write_packer #(
  parameter logic [17:0] MAX_ADDR = 18'h3FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_last,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [53:0] wr_din,
  output logic        busy,
  output logic [17:0] words_written
);

  logic [17:0]      addr_r;
  logic [1:0]       count_r;
  logic [2:0][7:0]  pend_r;
  logic [53:0]      out_r;
  logic             wr_valid_r;
  logic [17:0]      words_r;

  logic             pix_fire_s;
  logic             wr_fire_s;
  logic             complete_s;
  logic             load_s;
  logic [17:0]      addr_next_s;
  logic [31:0]      word_data_s;

  // Byte-enable for a word whose highest valid lane is last_lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
    logic [3:0] m;
    case (last_lane)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      2'd3:    m = 4'b1111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign pix_ready   = ~start & (~wr_valid_r | wr_ready);
  assign pix_fire_s  = pix_valid & pix_ready;
  assign wr_fire_s   = wr_valid_r & wr_ready;
  assign complete_s  = (count_r == 2'd3) | pix_last;
  assign load_s      = pix_fire_s & complete_s;
  assign addr_next_s = (addr_r == MAX_ADDR) ? 18'h00000 : addr_r + 18'd1;

  // Word assembly: pending lanes, the incoming pixel at lane count, zeros above.
  always_comb begin
    word_data_s = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < count_r) begin
        word_data_s[8*i +: 8] = pend_r[i];
      end else if (2'(i) == count_r) begin
        word_data_s[8*i +: 8] = pix_data;
      end else begin
        word_data_s[8*i +: 8] = 8'h00;
      end
    end
    if (count_r == 2'd3) begin
      word_data_s[31:24] = pix_data;
    end else begin
      word_data_s[31:24] = 8'h00;
    end
  end

  // Packing register, address counter and handshake counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r  <= 18'h00000;
      count_r <= 2'd0;
      pend_r  <= '0;
      words_r <= 18'h00000;
    end else if (start) begin
      addr_r  <= base_addr;
      count_r <= 2'd0;
      words_r <= 18'h00000;
    end else begin
      if (wr_fire_s) begin
        words_r <= words_r + 18'd1;
      end
      if (pix_fire_s) begin
        if (complete_s) begin
          count_r <= 2'd0;
          addr_r  <= addr_next_s;
        end else begin
          count_r <= count_r + 2'd1;
          case (count_r)
            2'd0:    pend_r[0] <= pix_data;
            2'd1:    pend_r[1] <= pix_data;
            2'd2:    pend_r[2] <= pix_data;
            default: pend_r    <= pend_r;
          endcase
        end
      end
    end
  end

  // Output word register; a load on a draining edge keeps wr_valid high (no bubble).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_r      <= 54'h0;
      wr_valid_r <= 1'b0;
    end else if (load_s) begin
      out_r      <= {lane_mask(count_r), addr_r, word_data_s};
      wr_valid_r <= 1'b1;
    end else if (wr_fire_s) begin
      wr_valid_r <= 1'b0;
    end else begin
      wr_valid_r <= wr_valid_r;
    end
  end

  assign wr_valid      = wr_valid_r;
  assign wr_din        = out_r;
  assign words_written = words_r;
  assign busy          = (count_r != 2'd0) | wr_valid_r;

endmodule

// File: tb/tb_pixel_write_packer.sv
// Directed bench for pixel_write_packer: cycle table for packing/handshake
// behaviour plus hand sequences for stall, address wrap, restart and reset.
module tb_pixel_write_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] base_addr;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [53:0] wr_din;
  logic        busy;
  logic [17:0] words_written;

  int total = 0;
  int bad   = 0;
  logic [53:0] wq[$];

  pixel_write_packer #(.MAX_ADDR(18'h3FFFF)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_last(pix_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_din(wr_din), .busy(busy), .words_written(words_written)
  );

  always #5 clock = ~clock;

  // Records every word that will be consumed on the coming rising edge.
  always begin
    @(negedge clock);
    #1;
    if (reset && wr_valid && wr_ready) wq.push_back(wr_din);
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic        st;
    logic [17:0] base;
    logic        pv;
    logic [7:0]  pd;
    logic        pl;
    logic        wrr;
    logic        e_rdy;
    logic        e_wv;
    logic [53:0] e_din;
    logic [17:0] e_ww;
    logic        e_busy;
  } vec_t;

  function automatic logic [53:0] mk(input logic [3:0] m, input logic [17:0] a, input logic [31:0] d);
    return {m, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_start(input logic [17:0] b);
    @(negedge clock);
    start = 1'b1; base_addr = b; pix_valid = 1'b0; pix_last = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clock);
    pix_valid = 1'b1; pix_data = d; pix_last = l;
    #1;
    while (!pix_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!pix_ready) chk("pix_accept_timeout", 64'(pix_ready), 64'd1);
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    pix_valid = 1'b0; pix_last = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  vec_t vecs[16];
  logic [53:0] w;

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = 18'h0; pix_valid = 1'b0;
    pix_data = 8'h00; pix_last = 1'b0; wr_ready = 1'b1;

    vecs[0]  = '{1'b1, 18'h00100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 54'h0, 18'd0, 1'b0};
    vecs[1]  = '{1'b0, 18'h0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 54'h0, 18'd0, 1'b1};
    vecs[2]  = '{1'b0, 18'h0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 54'h0, 18'd0, 1'b1};
    vecs[3]  = '{1'b0, 18'h0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 54'h0, 18'd0, 1'b1};
    vecs[4]  = '{1'b0, 18'h0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, mk(4'hF, 18'h00100, 32'h44332211), 18'd0, 1'b1};
    vecs[5]  = '{1'b0, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'hF, 18'h00100, 32'h44332211), 18'd1, 1'b0};
    vecs[6]  = '{1'b0, 18'h0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'hF, 18'h00100, 32'h44332211), 18'd1, 1'b1};
    vecs[7]  = '{1'b0, 18'h0, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'hF, 18'h00100, 32'h44332211), 18'd1, 1'b1};
    vecs[8]  = '{1'b0, 18'h0, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, mk(4'h7, 18'h00101, 32'h00CCBBAA), 18'd1, 1'b1};
    vecs[9]  = '{1'b0, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'h7, 18'h00101, 32'h00CCBBAA), 18'd2, 1'b0};
    vecs[10] = '{1'b0, 18'h0, 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, 1'b1, mk(4'h1, 18'h00102, 32'h000000DD), 18'd2, 1'b1};
    vecs[11] = '{1'b0, 18'h0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, mk(4'h1, 18'h00102, 32'h000000DD), 18'd2, 1'b1};
    vecs[12] = '{1'b0, 18'h0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'h1, 18'h00102, 32'h000000DD), 18'd3, 1'b1};
    vecs[13] = '{1'b0, 18'h0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, mk(4'h3, 18'h00103, 32'h0000FFEE), 18'd3, 1'b1};
    vecs[14] = '{1'b0, 18'h0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, mk(4'h1, 18'h00104, 32'h0000005A), 18'd4, 1'b1};
    vecs[15] = '{1'b0, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, mk(4'h1, 18'h00104, 32'h0000005A), 18'd5, 1'b0};

    repeat (3) @(negedge clock);
    #1;
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_din", 64'(wr_din), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      start = vecs[i].st; base_addr = vecs[i].base; pix_valid = vecs[i].pv;
      pix_data = vecs[i].pd; pix_last = vecs[i].pl; wr_ready = vecs[i].wrr;
      #1;
      chk($sformatf("v%0d_pix_ready", i), 64'(pix_ready), 64'(vecs[i].e_rdy));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_wr_valid", i), 64'(wr_valid), 64'(vecs[i].e_wv));
      chk($sformatf("v%0d_wr_din", i), 64'(wr_din), 64'(vecs[i].e_din));
      chk($sformatf("v%0d_words", i), 64'(words_written), 64'(vecs[i].e_ww));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
    end
    start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;

    // Backpressure: word held, no pixels taken, then resume on wr_ready.
    wq.delete();
    wr_ready = 1'b0;
    do_start(18'h00010);
    send_pix(8'h10, 1'b0); send_pix(8'h11, 1'b0);
    send_pix(8'h12, 1'b0); send_pix(8'h13, 1'b0);
    w = mk(4'hF, 18'h00010, 32'h13121110);
    @(negedge clock);
    pix_valid = 1'b1; pix_data = 8'h20; pix_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_pix_ready", 64'(pix_ready), 64'd0);
      chk("stall_wr_din", 64'(wr_din), 64'(w));
      @(negedge clock);
    end
    wr_ready = 1'b1;
    #1;
    chk("resume_pix_ready", 64'(pix_ready), 64'd1);
    @(posedge clock);
    #1 pix_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("resume_words", 64'(words_written), 64'd1);
    chk("resume_busy", 64'(busy), 64'd1);
    chk("resume_wr_valid", 64'(wr_valid), 64'd0);
    chk("stall_qsize", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) chk("stall_word", 64'(wq[0]), 64'(w));

    // Address wrap at MAX_ADDR.
    wq.delete();
    do_start(18'h3FFFF);
    for (int p = 1; p <= 8; p++) send_pix(8'(p), 1'b0);
    idle(3);
    chk("wrap_qsize", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      chk("wrap_word0", 64'(wq[0]), 64'(mk(4'hF, 18'h3FFFF, 32'h04030201)));
      chk("wrap_word1", 64'(wq[1]), 64'(mk(4'hF, 18'h00000, 32'h08070605)));
    end

    // Restart discards pending bytes.
    wq.delete();
    do_start(18'h00000);
    send_pix(8'h09, 1'b0); send_pix(8'h0A, 1'b0);
    do_start(18'h00200);
    for (int p = 1; p <= 4; p++) send_pix(8'(p), 1'b0);
    idle(3);
    #1;
    chk("restart_qsize", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) chk("restart_word", 64'(wq[0]), 64'(mk(4'hF, 18'h00200, 32'h04030201)));
    chk("restart_words", 64'(words_written), 64'd1);

    // Asynchronous reset while a word is pending.
    wr_ready = 1'b0;
    do_start(18'h00040);
    send_pix(8'h30, 1'b0); send_pix(8'h31, 1'b0);
    send_pix(8'h32, 1'b0); send_pix(8'h33, 1'b0);
    @(negedge clock);
    pix_valid = 1'b0;
    #1;
    chk("prerst_wr_valid", 64'(wr_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_wr_valid", 64'(wr_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_wr_din", 64'(wr_din), 64'd0);
    chk("async_words", 64'(words_written), 64'd0);
    wq.delete();
    @(negedge clock);
    wr_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_rst_pix_ready", 64'(pix_ready), 64'd1);
    repeat (3) @(negedge clock);
    #2;
    chk("post_rst_qsize", 64'(wq.size()), 64'd0);
    chk("post_rst_wr_valid", 64'(wr_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
